// File: rtl/nand_stim_sequencer_pkg.sv
// Shared types and constants for the NAND stimulus sequencer: sequence modes,
// FSM state encoding and sequence lengths.
package nand_stim_pkg;

    typedef enum logic [1:0] {
        MODE_BIN     = 2'b00,
        MODE_GRAY    = 2'b01,
        MODE_WALK    = 2'b10,
        MODE_BIN_ALT = 2'b11
    } mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int LEN_BIN  = 8;
    localparam int LEN_WALK = 3;

    // Unused encoding 11 falls through to the binary length.
    function automatic logic [2:0] last_idx(input mode_t m);
        return (m == MODE_WALK) ? 3'(LEN_WALK - 1) : 3'(LEN_BIN - 1);
    endfunction

endpackage

// File: rtl/nand_stim_sequencer_if.sv
// Control and stimulus bundle between a sequencer (slave) and whatever drives
// its configuration and observes the applied vector (master).
interface nand_stim_sequencer_if #(
    parameter int DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic [1:0]         mode;
    logic [DWELL_W-1:0] dwell;
    logic               loop;
    logic               a;
    logic               b;
    logic               c;
    logic [2:0]         vec_idx;
    logic               vec_new;
    logic               busy;
    logic               done;

    modport master (
        output start, stop, mode, dwell, loop,
        input  a, b, c, vec_idx, vec_new, busy, done
    );

    modport slave (
        input  start, stop, mode, dwell, loop,
        output a, b, c, vec_idx, vec_new, busy, done
    );
endinterface

// File: rtl/nand_stim_sequencer_vec_map.sv
// Combinational (mode, index) -> {a,b,c} mapping for binary, Gray and
// walking-one sequences.
module stim_vec_map
    import nand_stim_pkg::*;
(
    input  mode_t      mode,
    input  logic [2:0] idx,
    output logic [2:0] vec
);

    always_comb begin
        vec = 3'b000;
        case (mode)
            MODE_GRAY: vec = idx ^ (idx >> 1);
            MODE_WALK: vec = (idx < 3'(LEN_WALK)) ? (3'b001 << idx) : 3'b000;
            default:   vec = idx;
        endcase
    end

endmodule

// File: rtl/nand_stim_sequencer.sv
// Clocked stimulus source for three-input gate blocks: steps a selectable
// vector sequence, holding each vector for a programmable dwell.
module nand_stim_sequencer
    import nand_stim_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    nand_stim_sequencer_if.slave   bus
);

    state_t             state_q, state_d;
    mode_t              mode_q, mode_d;
    logic               loop_q, loop_d;
    logic [DWELL_W-1:0] reload_q, reload_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [2:0]         vec_q, vec_d;
    logic               vec_new_q, vec_new_d;
    logic               done_q, done_d;

    logic               launch, advance, finish;
    logic [DWELL_W-1:0] dwell_m1;
    logic [2:0]         map_vec;

    // A dwell of zero behaves as one, so the reload value saturates at zero.
    assign dwell_m1 = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_W'(1);

    // The map looks at next-cycle mode/index so the vector lands in the same
    // edge as the index it belongs to.
    stim_vec_map u_map (
        .mode (mode_d),
        .idx  (idx_d),
        .vec  (map_vec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_BIN;
            loop_q    <= 1'b0;
            reload_q  <= '0;
            cnt_q     <= '0;
            idx_q     <= 3'd0;
            vec_q     <= 3'b000;
            vec_new_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            loop_q    <= loop_d;
            reload_q  <= reload_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            vec_q     <= vec_d;
            vec_new_q <= vec_new_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        loop_d   = loop_q;
        reload_d = reload_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        launch   = 1'b0;
        advance  = 1'b0;
        finish   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d  = ST_RUN;
                    mode_d   = mode_t'(bus.mode);
                    loop_d   = bus.loop;
                    reload_d = dwell_m1;
                    cnt_d    = dwell_m1;
                    idx_d    = 3'd0;
                    launch   = 1'b1;
                end
            end
            ST_RUN: begin
                // stop outranks any advance or completion due this cycle
                if (bus.stop) begin
                    state_d = ST_IDLE;
                    idx_d   = 3'd0;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    if (idx_q == last_idx(mode_q)) begin
                        if (loop_q) begin
                            idx_d   = 3'd0;
                            cnt_d   = reload_q;
                            advance = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            idx_d   = 3'd0;
                            finish  = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        cnt_d   = reload_q;
                        advance = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        vec_new_d = launch | advance;
        done_d    = finish;
        vec_d     = (state_d == ST_RUN) ? map_vec : 3'b000;
    end

    assign {bus.a, bus.b, bus.c} = vec_q;
    assign bus.vec_idx           = idx_q;
    assign bus.vec_new           = vec_new_q;
    assign bus.busy              = (state_q == ST_RUN);
    assign bus.done              = done_q;

endmodule

// File: tb/tb_nand_stim_sequencer.sv
// Scoreboard bench for nand_stim_sequencer: stimulus queues the expected
// per-cycle output word, a negedge monitor pops and compares.
module tb_nand_stim_sequencer;
    import nand_stim_pkg::*;

    localparam int DWELL_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nand_stim_sequencer_if #(.DWELL_W(DWELL_W)) bus ();

    nand_stim_sequencer #(.DWELL_W(DWELL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [8:0] sb[$];
    logic [8:0] obs;

    // {busy, done, vec_new, vec_idx[2:0], a, b, c}
    assign obs = {bus.busy, bus.done, bus.vec_new, bus.vec_idx, bus.a, bus.b, bus.c};

    logic [2:0] bin_tab  [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [2:0] gray_tab [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    logic [2:0] walk_tab [8] = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};

    function automatic logic [8:0] ent(input logic busy, input logic done, input logic vnew,
                                       input logic [2:0] idx, input logic [2:0] vec);
        return {busy, done, vnew, idx, vec};
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [8:0] e;
        if (rst_n && (bus.busy || bus.done)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output got %h exp none", obs);
            end else begin
                e = sb.pop_front();
                check("scoreboard", int'(obs), int'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [2:0] tab[8], input int len, input int dw, input bit with_done);
        for (int k = 0; k < len; k++)
            for (int d = 0; d < dw; d++)
                sb.push_back(ent(1'b1, 1'b0, d == 0, 3'(k), tab[k]));
        if (with_done) sb.push_back(ent(1'b0, 1'b1, 1'b0, 3'd0, 3'b000));
    endtask

    task automatic start_run(input logic [1:0] m, input int dw, input bit lp);
        bus.mode  = m;
        bus.dwell = DWELL_W'(dw);
        bus.loop  = lp;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.mode  = 2'b00;
        bus.dwell = '0;
        bus.loop  = 1'b0;
        repeat (3) tick();
        check("reset_state", int'(obs), 0);
        rst_n = 1'b1;
        tick();
        check("idle_after_reset", int'(obs), 0);

        // binary, dwell 1
        push_seq(bin_tab, 8, 1, 1'b1);
        start_run(2'b00, 1, 1'b0);
        repeat (12) tick();
        check("bin_drain", sb.size(), 0);
        check("bin_idle", int'(obs), 0);

        // Gray, dwell 2
        push_seq(gray_tab, 8, 2, 1'b1);
        start_run(2'b01, 2, 1'b0);
        repeat (20) tick();
        check("gray_drain", sb.size(), 0);

        // walking-one, dwell 0 acts as 1
        push_seq(walk_tab, 3, 1, 1'b1);
        start_run(2'b10, 0, 1'b0);
        repeat (6) tick();
        check("walk_drain", sb.size(), 0);

        // looping binary, start and config wiggled mid-run, stop sampled at edge 12
        for (int c = 0; c < 12; c++)
            sb.push_back(ent(1'b1, 1'b0, 1'b1, 3'(c % 8), bin_tab[c % 8]));
        start_run(2'b00, 1, 1'b1);
        repeat (4) tick();
        bus.start = 1'b1;
        bus.mode  = 2'b10;
        bus.dwell = DWELL_W'(5);
        bus.loop  = 1'b0;
        tick();
        bus.start = 1'b0;
        repeat (6) tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        tick();
        check("stop_idle", int'(obs), 0);
        repeat (3) tick();
        check("loop_drain", sb.size(), 0);

        // asynchronous reset in the middle of a vector
        push_seq(bin_tab, 8, 3, 1'b1);
        start_run(2'b00, 3, 1'b0);
        repeat (4) tick();
        #2;
        sb.delete();
        rst_n = 1'b0;
        #1;
        check("async_reset", int'(obs), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("post_reset_idle", int'(obs), 0);
        push_seq(bin_tab, 8, 1, 1'b1);
        start_run(2'b00, 1, 1'b0);
        repeat (12) tick();
        check("restart_drain", sb.size(), 0);

        // mode 11 behaves as binary, dwell 3
        push_seq(bin_tab, 8, 3, 1'b1);
        start_run(2'b11, 3, 1'b0);
        repeat (28) tick();
        check("mode11_drain", sb.size(), 0);

        // start and stop together in IDLE: no launch
        bus.mode  = 2'b00;
        bus.dwell = DWELL_W'(1);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check("start_stop_idle", int'(obs), 0);
        tick();
        check("start_stop_idle2", int'(obs), 0);
        check("final_drain", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
